// File: rtl/pool_window_sequencer.sv
// Captures one feature map in 9-lane batches, then emits one 2x2 stride-2 max/avg result per window.
// Define POOL_ROUND_EN to round averages half up; by default the average is floored.
module pool_window_sequencer #(
  parameter int DATA_W = 12,
  parameter int FM_H   = 7,
  parameter int FM_W   = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                mode,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [9*DATA_W-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_last,
  output logic                busy,
  output logic                done
);

  localparam int N  = FM_H * FM_W;
  localparam int NB = (N + 8) / 9;
  localparam int PH = FM_H / 2;
  localparam int PW = FM_W / 2;
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = $clog2(NB + 1);
  localparam int RW = (FM_H > 1) ? $clog2(FM_H) : 1;
  localparam int CW = (FM_W > 1) ? $clog2(FM_W) : 1;
  localparam int SW = DATA_W + 2;

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_ACC, S_EMIT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic                mode_q, mode_d;
  logic [BW-1:0]       batch_q, batch_d;
  logic [RW-1:0]       row_q, row_d;
  logic [CW-1:0]       col_q, col_d;
  logic [1:0]          tap_q, tap_d;
  logic [SW-1:0]       acc_q, acc_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_last_q, out_last_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [DATA_W-1:0]   fm_mem [N];
  logic                accept;
  logic [8:0]          lane_en;
  logic [AW-1:0]       lane_addr [9];
  int                  rd_row, rd_col;
  logic [AW-1:0]       rd_addr;
  logic [DATA_W-1:0]   rd_data;
  logic [SW-1:0]       sum;
  logic [DATA_W-1:0]   max_val;
  logic                last_row, last_col;

  assign accept = (state_q == S_FILL) && in_valid && in_ready_q;

  // Lanes past the end of the map (only possible in the final batch) are dropped.
  always_comb begin
    for (int l = 0; l < 9; l++) begin
      lane_en[l]   = (9 * int'(batch_q) + l) < N;
      lane_addr[l] = AW'(9 * int'(batch_q) + l);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int l = 0; l < 9; l++) begin
        if (lane_en[l]) fm_mem[lane_addr[l]] <= in_data[l*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    rd_row  = 2 * int'(row_q) + int'(tap_q[1]);
    rd_col  = 2 * int'(col_q) + int'(tap_q[0]);
    rd_addr = AW'(rd_row * FM_W + rd_col);
  end

  assign rd_data  = fm_mem[rd_addr];
  assign last_row = (int'(row_q) == PH - 1);
  assign last_col = (int'(col_q) == PW - 1);

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    batch_d     = batch_q;
    row_d       = row_q;
    col_d       = col_q;
    tap_d       = tap_q;
    acc_d       = acc_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    sum         = acc_q + SW'(rd_data);
    max_val     = (rd_data > acc_q[DATA_W-1:0]) ? rd_data : acc_q[DATA_W-1:0];

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d     = mode;
          batch_d    = '0;
          row_d      = '0;
          col_d      = '0;
          tap_d      = '0;
          acc_d      = '0;
          in_ready_d = 1'b1;
          busy_d     = 1'b1;
          state_d    = S_FILL;
        end
      end
      S_FILL: begin
        if (accept) begin
          batch_d = batch_q + 1'b1;
          if (int'(batch_q) == NB - 1) begin
            in_ready_d = 1'b0;
            if (PH == 0 || PW == 0) begin
              done_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              state_d = S_ACC;
            end
          end
        end
      end
      S_ACC: begin
        tap_d = tap_q + 2'd1;
        if (tap_q == 2'd0) acc_d = SW'(rd_data);
        else if (mode_q)   acc_d = sum;
        else               acc_d = SW'(max_val);
        if (tap_q == 2'd3) begin
          out_valid_d = 1'b1;
          out_last_d  = last_row && last_col;
          state_d     = S_EMIT;
          if (mode_q) begin
`ifdef POOL_ROUND_EN
            out_data_d = DATA_W'((sum + SW'(2)) >> 2);
`else
            out_data_d = DATA_W'(sum >> 2);
`endif
          end else begin
            out_data_d = max_val;
          end
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          tap_d       = '0;
          if (last_row && last_col) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else if (last_col) begin
            col_d   = '0;
            row_d   = row_q + 1'b1;
            state_d = S_ACC;
          end else begin
            col_d   = col_q + 1'b1;
            state_d = S_ACC;
          end
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mode_q      <= 1'b0;
      batch_q     <= '0;
      row_q       <= '0;
      col_q       <= '0;
      tap_q       <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      batch_q     <= batch_d;
      row_q       <= row_d;
      col_q       <= col_d;
      tap_q       <= tap_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_pool_window_sequencer.sv
// Directed bench for pool_window_sequencer: a 4x4 instance for the main frames and a 7x7 instance
// for the saturated average frame; expectations follow POOL_ROUND_EN when it is defined.
module tb_pool_window_sequencer;

  localparam int DW = 12;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic            mode = 1'b0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b1;
  logic            sel7 = 1'b0;
  logic [9*DW-1:0] in_data = '0;

  logic            ir4, ov4, ol4, busy4, done4;
  logic [DW-1:0]   od4;
  logic            ir7, ov7, ol7, busy7, done7;
  logic [DW-1:0]   od7;

  logic            in_ready_o, out_valid_o, out_last_o, busy_o, done_o;
  logic [DW-1:0]   out_data_o;

  int vectors = 0;
  int miscompares = 0;
  int avg_exp [4];

  always #5 clk = ~clk;

  pool_window_sequencer #(.DATA_W(DW), .FM_H(4), .FM_W(4)) dut4 (
    .clk(clk), .reset(reset), .start(start && !sel7), .mode(mode),
    .in_valid(in_valid && !sel7), .in_ready(ir4), .in_data(in_data),
    .out_valid(ov4), .out_ready(out_ready), .out_data(od4), .out_last(ol4),
    .busy(busy4), .done(done4)
  );

  pool_window_sequencer #(.DATA_W(DW), .FM_H(7), .FM_W(7)) dut7 (
    .clk(clk), .reset(reset), .start(start && sel7), .mode(mode),
    .in_valid(in_valid && sel7), .in_ready(ir7), .in_data(in_data),
    .out_valid(ov7), .out_ready(out_ready), .out_data(od7), .out_last(ol7),
    .busy(busy7), .done(done7)
  );

  assign in_ready_o  = sel7 ? ir7   : ir4;
  assign out_valid_o = sel7 ? ov7   : ov4;
  assign out_data_o  = sel7 ? od7   : od4;
  assign out_last_o  = sel7 ? ol7   : ol4;
  assign busy_o      = sel7 ? busy7 : busy4;
  assign done_o      = sel7 ? done7 : done4;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Element e carries value e; lanes beyond the 16-element map carry junk.
  function automatic logic [9*DW-1:0] pack4(input int b);
    logic [9*DW-1:0] p;
    for (int l = 0; l < 9; l++) begin
      int e = 9 * b + l;
      p[l*DW +: DW] = (e < 16) ? DW'(e) : DW'(12'hABC);
    end
    return p;
  endfunction

  // Saturated map whose discarded row 6 / column 6 hold zeros.
  function automatic logic [9*DW-1:0] pack7(input int b);
    logic [9*DW-1:0] p;
    for (int l = 0; l < 9; l++) begin
      int e = 9 * b + l;
      if (e >= 49)                        p[l*DW +: DW] = DW'(12'h5A5);
      else if (e / 7 == 6 || e % 7 == 6)  p[l*DW +: DW] = '0;
      else                                p[l*DW +: DW] = DW'(4095);
    end
    return p;
  endfunction

  task automatic applyStimulus(input logic [9*DW-1:0] data);
    int n = 0;
    in_data  = data;
    in_valid = 1'b1;
    while (!in_ready_o && n < 20) begin
      tick;
      n++;
    end
    checkOutput("batch_in_ready", in_ready_o, 1);
    tick;
    in_valid = 1'b0;
  endtask

  task automatic startFrame(input logic m);
    start = 1'b1;
    mode  = m;
    tick;
    start = 1'b0;
    checkOutput("start_in_ready", in_ready_o, 1);
    checkOutput("start_busy", busy_o, 1);
  endtask

  task automatic collectWindow(input string tag, input int exp_data, input logic exp_last, input int exp_wait);
    int n = 0;
    while (!out_valid_o && n < 50) begin
      tick;
      n++;
    end
    checkOutput({tag, "_valid"}, out_valid_o, 1);
    if (exp_wait >= 0) checkOutput({tag, "_latency"}, n, exp_wait);
    checkOutput({tag, "_data"}, out_data_o, exp_data);
    checkOutput({tag, "_last"}, out_last_o, exp_last);
    tick;
  endtask

  task automatic checkFrameEnd(input string tag);
    checkOutput({tag, "_done_pulse"}, done_o, 1);
    checkOutput({tag, "_busy_in_done"}, busy_o, 1);
    tick;
    checkOutput({tag, "_done_clear"}, done_o, 0);
    checkOutput({tag, "_busy_clear"}, busy_o, 0);
    checkOutput({tag, "_valid_clear"}, out_valid_o, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
`ifdef POOL_ROUND_EN
    avg_exp = '{3, 5, 11, 13};
`else
    avg_exp = '{2, 4, 10, 12};
`endif

    tick;
    tick;
    checkOutput("rst_in_ready", in_ready_o, 0);
    checkOutput("rst_out_valid", out_valid_o, 0);
    checkOutput("rst_out_data", out_data_o, 0);
    checkOutput("rst_out_last", out_last_o, 0);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_done", done_o, 0);
    reset = 1'b0;

    in_data  = pack4(0);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      checkOutput("idle_in_ready", in_ready_o, 0);
      checkOutput("idle_busy", busy_o, 0);
    end
    in_valid = 1'b0;

    $display("[TB] frame A: 4x4 max pooling");
    startFrame(1'b0);
    applyStimulus(pack4(0));
    applyStimulus(pack4(1));
    collectWindow("maxA_w0", 5, 1'b0, 4);
    collectWindow("maxA_w1", 7, 1'b0, 4);
    collectWindow("maxA_w2", 13, 1'b0, 4);
    collectWindow("maxA_w3", 15, 1'b1, 4);
    checkFrameEnd("maxA");

    $display("[TB] frame B: 4x4 average with backpressure and stray starts");
    startFrame(1'b1);
    applyStimulus(pack4(0));
    applyStimulus(pack4(1));
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    checkOutput("avgB_w0_valid", out_valid_o, 1);
    checkOutput("avgB_w0_data", out_data_o, avg_exp[0]);
    for (int i = 0; i < 10; i++) begin
      tick;
      checkOutput("stall_valid", out_valid_o, 1);
      checkOutput("stall_data", out_data_o, avg_exp[0]);
    end
    out_ready = 1'b1;
    tick;
    start = 1'b1;
    tick;
    start = 1'b0;
    collectWindow("avgB_w1", avg_exp[1], 1'b0, 3);
    start = 1'b1;
    collectWindow("avgB_w2", avg_exp[2], 1'b0, 4);
    checkOutput("avgB_busy_mid", busy_o, 1);
    start = 1'b0;
    collectWindow("avgB_w3", avg_exp[3], 1'b1, 4);
    checkFrameEnd("avgB");

    $display("[TB] frame C: reset during fill, then a fresh frame");
    startFrame(1'b0);
    applyStimulus(pack4(0));
    reset = 1'b1;
    tick;
    reset = 1'b0;
    checkOutput("midrst_in_ready", in_ready_o, 0);
    checkOutput("midrst_busy", busy_o, 0);
    startFrame(1'b0);
    applyStimulus(pack4(0));
    applyStimulus(pack4(1));
    collectWindow("maxC_w0", 5, 1'b0, 4);
    collectWindow("maxC_w1", 7, 1'b0, 4);
    collectWindow("maxC_w2", 13, 1'b0, 4);
    collectWindow("maxC_w3", 15, 1'b1, 4);
    checkFrameEnd("maxC");

    $display("[TB] frame D: 7x7 saturated average");
    sel7 = 1'b1;
    startFrame(1'b1);
    for (int b = 0; b < 6; b++) applyStimulus(pack7(b));
    for (int w = 0; w < 9; w++) collectWindow("avgD", 4095, (w == 8), 4);
    checkFrameEnd("avgD");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
